// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Sequencing stage in front of the FP arithmetic unit. Takes one operation per
// req_valid/req_ready handshake, holds it on the fpu_* outputs with fpu_start
// high until fpu_done, then parks the result, destination tag and exception
// flags in a response register with its own rsp_valid/rsp_ready handshake.
// Retired flags are OR-accumulated into fflags_accrued (RISC-V CSR order
// {NV, DZ, OF, UF, NX}).
//
// Optional feature macro: FPU_CTRL_TIMEOUT_EN
//   defined   : BUSY aborts after TIMEOUT_CYCLES cycles without fpu_done and
//               returns a canonical qNaN with NV set and rsp_timeout=1.
//   undefined : BUSY waits for fpu_done indefinitely; rsp_timeout is 0.
//
// Parameters
//   TIMEOUT_CYCLES : abort threshold, 2..255 (used only with the macro)
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   req_*                    : request channel from decode/execute
//   fpu_start/op/rm/csr_frm/a/b/rs2_lsb : arithmetic unit inputs
//   fpu_result/done/flags    : arithmetic unit outputs
//   rsp_*                    : response channel
//   fflags_accrued/clear     : sticky exception flags and their clear
//   busy                     : high while an operation is in BUSY or RESP
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [2:0]  req_csr_frm,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_rs2_lsb,
    input  logic [4:0]  req_rd,

    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [2:0]  fpu_csr_frm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    input  logic        fpu_invalid,
    input  logic        fpu_inexact,
    input  logic        fpu_div_by_zero,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_rd,
    output logic [4:0]  rsp_fflags,
    output logic        rsp_timeout,

    output logic [4:0]  fflags_accrued,
    input  logic        fflags_clear,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
    localparam logic [4:0]  FLAG_NV    = 5'b10000;

    state_t state_q, state_d;

    // Issue registers: drive the arithmetic unit for the whole BUSY state.
    logic [4:0]  op_q;
    logic [2:0]  rm_q;
    logic [2:0]  csr_frm_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        rs2_lsb_q;
    logic [4:0]  rd_q;

    // Response registers.
    logic [31:0] rsp_result_q;
    logic [4:0]  rsp_rd_q;
    logic [4:0]  rsp_fflags_q;
    logic        rsp_timeout_q;
    logic [4:0]  fflags_accrued_q;

    logic accept;
    logic capture;
    logic abort;
    logic retire;
    logic timeout_hit;

    // ------------------------------------------------------------------
    // Optional BUSY watchdog
    // ------------------------------------------------------------------
`ifdef FPU_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt_q;

    // A done in the same cycle as the limit takes the normal capture path.
    assign timeout_hit = (state_q == S_BUSY) && !fpu_done && (tmo_cnt_q == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= 8'd0;
        end else if (accept) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == S_BUSY && !fpu_done) begin
            // Never wraps: BUSY is left once the count equals the limit.
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
`endif

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Gated by reset so the request channel is closed during the reset cycle.
    assign req_ready = !reset && ((state_q == S_IDLE) || (state_q == S_RESP && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign retire    = (state_q == S_RESP) && rsp_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (fpu_done) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = req_valid ? S_BUSY : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            op_q             <= 5'd0;
            rm_q             <= 3'd0;
            csr_frm_q        <= 3'd0;
            a_q              <= 32'd0;
            b_q              <= 32'd0;
            rs2_lsb_q        <= 1'b0;
            rd_q             <= 5'd0;
            rsp_result_q     <= 32'd0;
            rsp_rd_q         <= 5'd0;
            rsp_fflags_q     <= 5'd0;
            rsp_timeout_q    <= 1'b0;
            fflags_accrued_q <= 5'd0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_q      <= req_op;
                rm_q      <= req_rm;
                csr_frm_q <= req_csr_frm;
                a_q       <= req_a;
                b_q       <= req_b;
                rs2_lsb_q <= req_rs2_lsb;
                rd_q      <= req_rd;
            end

            if (capture) begin
                rsp_result_q  <= fpu_result;
                rsp_rd_q      <= rd_q;
                rsp_fflags_q  <= {fpu_invalid, fpu_div_by_zero, fpu_overflow,
                                  fpu_underflow, fpu_inexact};
                rsp_timeout_q <= 1'b0;
            end else if (abort) begin
                rsp_result_q  <= CANON_QNAN;
                rsp_rd_q      <= rd_q;
                rsp_fflags_q  <= FLAG_NV;
                rsp_timeout_q <= 1'b1;
            end

            // Clear is applied before the retiring flags are ORed in.
            if (retire) begin
                fflags_accrued_q <= (fflags_clear ? 5'd0 : fflags_accrued_q) | rsp_fflags_q;
            end else if (fflags_clear) begin
                fflags_accrued_q <= 5'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fpu_start      = (state_q == S_BUSY);
    assign fpu_op         = op_q;
    assign fpu_rm         = rm_q;
    assign fpu_csr_frm    = csr_frm_q;
    assign fpu_a          = a_q;
    assign fpu_b          = b_q;
    assign fpu_rs2_lsb    = rs2_lsb_q;

    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_result     = rsp_result_q;
    assign rsp_rd         = rsp_rd_q;
    assign rsp_fflags     = rsp_fflags_q;
    assign rsp_timeout    = rsp_timeout_q;

    assign fflags_accrued = fflags_accrued_q;
    assign busy           = (state_q != S_IDLE);

endmodule
